// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and sequencer between two requesters and the single-port data memory.
// Serialises one access at a time, filters out-of-window addresses and returns captured read data.
`timescale 1ns/1ps
module data_mem_arbiter #(
   parameter logic [31:0] BASE_ADDR  = 32'h6600_0000,
   parameter logic [31:0] LIMIT_ADDR = 32'h6600_00FC
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req0_valid_i,
   input  logic        req0_we_i,
   input  logic [31:0] req0_addr_i,
   input  logic [31:0] req0_wd_i,
   output logic        req0_ready_o,
   output logic        req0_rvalid_o,
   output logic [31:0] req0_rd_o,
   output logic        req0_err_o,
   input  logic        req1_valid_i,
   input  logic        req1_we_i,
   input  logic [31:0] req1_addr_i,
   input  logic [31:0] req1_wd_i,
   output logic        req1_ready_o,
   output logic        req1_rvalid_o,
   output logic [31:0] req1_rd_o,
   output logic        req1_err_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   output logic        mem_we_o,
   input  logic [31:0] mem_rd_i
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

   state_t      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        id_q, id_d;
   logic        we_q, we_d;
   logic        in_range_q, in_range_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wd_q, mem_wd_d;
   logic        mem_we_q, mem_we_d;
   logic        rvalid0_q, rvalid0_d;
   logic        rvalid1_q, rvalid1_d;
   logic [31:0] rd0_q, rd0_d;
   logic [31:0] rd1_q, rd1_d;
   logic        err0_q, err0_d;
   logic        err1_q, err1_d;

   logic        grant0, grant1;
   logic        accept;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wd;
   logic        sel_in_range;
   logic [31:0] cap_data;

   // Tie goes to whichever requester was not granted last.
   always_comb begin
      grant0 = req0_valid_i & (~req1_valid_i | last_grant_q);
      grant1 = req1_valid_i & (~req0_valid_i | ~last_grant_q);
      req0_ready_o = (state_q == IDLE) & ~rst_i & grant0;
      req1_ready_o = (state_q == IDLE) & ~rst_i & grant1;
      accept = req0_ready_o | req1_ready_o;
      sel_we   = grant1 ? req1_we_i   : req0_we_i;
      sel_addr = (grant1 ? req1_addr_i : req0_addr_i) & ~32'd3;
      sel_wd   = grant1 ? req1_wd_i   : req0_wd_i;
      sel_in_range = (sel_addr >= BASE_ADDR) && (sel_addr <= LIMIT_ADDR);
      cap_data = (we_q | ~in_range_q) ? '0 : mem_rd_i;
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      we_d         = we_q;
      in_range_d   = in_range_q;
      mem_addr_d   = '0;
      mem_wd_d     = '0;
      mem_we_d     = 1'b0;
      rvalid0_d    = 1'b0;
      rvalid1_d    = 1'b0;
      rd0_d        = '0;
      rd1_d        = '0;
      err0_d       = 1'b0;
      err1_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               id_d         = req1_ready_o;
               last_grant_d = req1_ready_o;
               we_d         = sel_we;
               in_range_d   = sel_in_range;
               // Memory port is loaded here so it is presented during ISSUE.
               if (sel_in_range) begin
                  mem_addr_d = sel_addr;
                  mem_wd_d   = sel_wd;
                  mem_we_d   = sel_we;
               end
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = CAPTURE;
         CAPTURE: begin
            if (id_q) begin
               rvalid1_d = 1'b1;
               rd1_d     = cap_data;
               err1_d    = ~in_range_q;
            end else begin
               rvalid0_d = 1'b1;
               rd0_d     = cap_data;
               err0_d    = ~in_range_q;
            end
            state_d = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         we_q         <= 1'b0;
         in_range_q   <= 1'b0;
         mem_addr_q   <= '0;
         mem_wd_q     <= '0;
         mem_we_q     <= 1'b0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
         rd0_q        <= '0;
         rd1_q        <= '0;
         err0_q       <= 1'b0;
         err1_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         we_q         <= we_d;
         in_range_q   <= in_range_d;
         mem_addr_q   <= mem_addr_d;
         mem_wd_q     <= mem_wd_d;
         mem_we_q     <= mem_we_d;
         rvalid0_q    <= rvalid0_d;
         rvalid1_q    <= rvalid1_d;
         rd0_q        <= rd0_d;
         rd1_q        <= rd1_d;
         err0_q       <= err0_d;
         err1_q       <= err1_d;
      end
   end

   assign mem_addr_o    = mem_addr_q;
   assign mem_wd_o      = mem_wd_q;
   assign mem_we_o      = mem_we_q;
   assign req0_rvalid_o = rvalid0_q;
   assign req0_rd_o     = rd0_q;
   assign req0_err_o    = err0_q;
   assign req1_rvalid_o = rvalid1_q;
   assign req1_rd_o     = rd1_q;
   assign req1_err_o    = err1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small registered-read memory attached to the port.
`timescale 1ns/1ps
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_valid, r0_we, r0_ready, r0_rvalid, r0_err;
   logic [31:0] r0_addr, r0_wd, r0_rd;
   logic        r1_valid, r1_we, r1_ready, r1_rvalid, r1_err;
   logic [31:0] r1_addr, r1_wd, r1_rd;
   logic [31:0] mem_addr, mem_wd, mem_rd;
   logic        mem_we;

   int unsigned tests = 0;
   int unsigned fails = 0;

   logic [31:0] mem [0:63];

   always #5 clk = ~clk;

   // Memory only decodes the word index, so a stray write lands somewhere visible.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
      mem_rd <= mem[mem_addr[7:2]];
   end

   data_mem_arbiter #(
      .BASE_ADDR (32'h6600_0000),
      .LIMIT_ADDR(32'h6600_00FC)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req0_valid_i (r0_valid),
      .req0_we_i    (r0_we),
      .req0_addr_i  (r0_addr),
      .req0_wd_i    (r0_wd),
      .req0_ready_o (r0_ready),
      .req0_rvalid_o(r0_rvalid),
      .req0_rd_o    (r0_rd),
      .req0_err_o   (r0_err),
      .req1_valid_i (r1_valid),
      .req1_we_i    (r1_we),
      .req1_addr_i  (r1_addr),
      .req1_wd_i    (r1_wd),
      .req1_ready_o (r1_ready),
      .req1_rvalid_o(r1_rvalid),
      .req1_rd_o    (r1_rd),
      .req1_err_o   (r1_err),
      .mem_addr_o   (mem_addr),
      .mem_wd_o     (mem_wd),
      .mem_we_o     (mem_we),
      .mem_rd_i     (mem_rd)
   );

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit id, input logic v, input logic we,
                        input logic [31:0] a, input logic [31:0] d);
      if (id) begin
         r1_valid = v; r1_we = we; r1_addr = a; r1_wd = d;
      end else begin
         r0_valid = v; r0_we = we; r0_addr = a; r0_wd = d;
      end
   endtask

   // Starts at a negedge in IDLE, ends at the negedge of T+4 (IDLE again).
   task automatic txn(input string tag, input bit id, input logic we,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_maddr, input logic exp_mwe,
                      input logic [31:0] exp_rd, input logic exp_err);
      drive(id, 1'b1, we, addr, wd);
      #1;
      check1({tag, ".ready"}, id ? r1_ready : r0_ready, 1'b1);
      @(negedge clk);
      drive(id, 1'b0, 1'b0, '0, '0);
      check32({tag, ".mem_addr"}, mem_addr, exp_maddr);
      check1({tag, ".mem_we"}, mem_we, exp_mwe);
      if (exp_mwe) check32({tag, ".mem_wd"}, mem_wd, wd);
      @(negedge clk);
      check1({tag, ".rvalid_early"}, id ? r1_rvalid : r0_rvalid, 1'b0);
      @(negedge clk);
      check1({tag, ".rvalid"}, id ? r1_rvalid : r0_rvalid, 1'b1);
      check32({tag, ".rd"}, id ? r1_rd : r0_rd, exp_rd);
      check1({tag, ".err"}, id ? r1_err : r0_err, exp_err);
      check1({tag, ".other_rvalid"}, id ? r0_rvalid : r1_rvalid, 1'b0);
      @(negedge clk);
      check1({tag, ".rvalid_pulse"}, id ? r1_rvalid : r0_rvalid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      rst = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 32'h6600_0010, 32'hDEAD_BEEF);
      drive(1'b1, 1'b0, 1'b0, '0, '0);

      // Reset held two cycles with req0 already requesting.
      @(negedge clk);
      @(negedge clk);
      check1("rst.ready0", r0_ready, 1'b0);
      check1("rst.ready1", r1_ready, 1'b0);
      check1("rst.rvalid0", r0_rvalid, 1'b0);
      check1("rst.rvalid1", r1_rvalid, 1'b0);
      check32("rst.rd0", r0_rd, '0);
      check32("rst.rd1", r1_rd, '0);
      check1("rst.err0", r0_err, 1'b0);
      check1("rst.err1", r1_err, 1'b0);
      check32("rst.mem_addr", mem_addr, '0);
      check32("rst.mem_wd", mem_wd, '0);
      check1("rst.mem_we", mem_we, 1'b0);
      rst = 1'b0;

      txn("wr_beef", 1'b0, 1'b1, 32'h6600_0010, 32'hDEAD_BEEF, 32'h6600_0010, 1'b1, '0, 1'b0);
      txn("rd_beef", 1'b0, 1'b0, 32'h6600_0012, '0, 32'h6600_0010, 1'b0, 32'hDEAD_BEEF, 1'b0);
      txn("wr_w0", 1'b0, 1'b1, 32'h6600_0000, 32'h1111_1111, 32'h6600_0000, 1'b1, '0, 1'b0);
      txn("wr_w1", 1'b1, 1'b1, 32'h6600_0004, 32'h2222_2222, 32'h6600_0004, 1'b1, '0, 1'b0);
      txn("wr_top", 1'b0, 1'b1, 32'h6600_00FC, 32'hCAFE_F00D, 32'h6600_00FC, 1'b1, '0, 1'b0);

      // Out-of-window accesses: word index of both would alias into the memory.
      txn("oow_rd", 1'b1, 1'b0, 32'h6600_0100, '0, '0, 1'b0, '0, 1'b1);
      txn("oow_wr", 1'b1, 1'b1, 32'h65FF_FFFC, 32'h1234_5678, '0, 1'b0, '0, 1'b1);
      txn("rd_top", 1'b0, 1'b0, 32'h6600_00FC, '0, 32'h6600_00FC, 1'b0, 32'hCAFE_F00D, 1'b0);

      // Tie from reset: grants must go 0,1,0.
      rst = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 32'h6600_0000, '0);
      drive(1'b1, 1'b1, 1'b0, 32'h6600_0004, '0);
      #1;
      check1("tie.ready_in_rst", r0_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check1("tie.ready0", r0_ready, (k % 2) == 0);
         check1("tie.ready1", r1_ready, (k % 2) == 1);
         @(negedge clk);
         if (k == 2) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0);
            drive(1'b1, 1'b0, 1'b0, '0, '0);
         end
         check32("tie.mem_addr", mem_addr, (k % 2) ? 32'h6600_0004 : 32'h6600_0000);
         check1("tie.busy_ready", r0_ready | r1_ready, 1'b0);
         @(negedge clk);
         @(negedge clk);
         if ((k % 2) == 0) begin
            check1("tie.rvalid0", r0_rvalid, 1'b1);
            check32("tie.rd0", r0_rd, 32'h1111_1111);
            check1("tie.rvalid1_off", r1_rvalid, 1'b0);
            check32("tie.rd1_off", r1_rd, '0);
         end else begin
            check1("tie.rvalid1", r1_rvalid, 1'b1);
            check32("tie.rd1", r1_rd, 32'h2222_2222);
            check1("tie.rvalid0_off", r0_rvalid, 1'b0);
            check32("tie.rd0_off", r0_rd, '0);
         end
         @(negedge clk);
      end

      // Reset during CAPTURE drops the read with no response.
      drive(1'b0, 1'b1, 1'b0, 32'h6600_0010, '0);
      #1;
      check1("midrst.ready", r0_ready, 1'b1);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check1("midrst.rvalid0", r0_rvalid, 1'b0);
      check32("midrst.rd0", r0_rd, '0);
      check32("midrst.mem_addr", mem_addr, '0);
      check1("midrst.mem_we", mem_we, 1'b0);
      rst = 1'b0;
      txn("midrst.reissue", 1'b0, 1'b0, 32'h6600_0010, '0, 32'h6600_0010, 1'b0, 32'hDEAD_BEEF, 1'b0);

      // req1 pulses a write while busy and withdraws before IDLE.
      drive(1'b0, 1'b1, 1'b0, 32'h6600_0004, '0);
      #1;
      check1("cancel.ready0", r0_ready, 1'b1);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b1, 1'b1, 32'h6600_0008, 32'h5555_5555);
      #1;
      check1("cancel.ready1_busy", r1_ready, 1'b0);
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check1("cancel.rvalid0", r0_rvalid, 1'b1);
      check32("cancel.rd0", r0_rd, 32'h2222_2222);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check1("cancel.mem_we", mem_we, 1'b0);
         check1("cancel.rvalid1", r1_rvalid, 1'b0);
      end
      txn("cancel.readback", 1'b0, 1'b0, 32'h6600_0008, '0, 32'h6600_0008, 1'b0, '0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port round-robin arbiter and sequencer for the single-port data memory (`data_memory`, byte-addressed, 1-cycle registered read, window 0x66000000–0x660000FC).

- Requester 0 is the core load/store unit; requester 1 is the debug/DMA loader.
- Each requester has a valid/ready request channel and a one-cycle response pulse.
- The block serialises accesses onto the memory port, filters out-of-window addresses and captures read data.

## Interface
Parameters:
- BASE_ADDR, 32'h66000000, lowest legal address
- LIMIT_ADDR, 32'h660000FC, highest legal word address (inclusive)

Ports:
- clk_i  in  1  clock, all logic on posedge
- rst_i  in  1  reset, synchronous, active-high
- req0_valid_i  in  1  requester 0 has a request
- req0_we_i  in  1  1 = write, 0 = read
- req0_addr_i  in  32  byte address
- req0_wd_i  in  32  write data
- req0_ready_o  out  1  request accepted this cycle
- req0_rvalid_o  out  1  response pulse
- req0_rd_o  out  32  read data, valid with rvalid
- req0_err_o  out  1  address out of window, valid with rvalid
- req1_*: identical set for requester 1
- mem_addr_o  out  32  to memory addr_i
- mem_wd_o  out  32  to memory wd_i
- mem_we_o  out  1  to memory we_i
- mem_rd_i  in  32  from memory rd_o

## Operation
- FSM states: IDLE → ISSUE → CAPTURE → RESP → IDLE. Only one transaction is in flight.
- IDLE arbitration:
  - If exactly one requester is valid, it is granted.
  - If both are valid, the one not granted last is granted.
  - last_grant resets to 1, so req0 wins the first tie.
- Grant/acceptance:
  - reqN_ready_o is combinational, high only in IDLE for the granted N.
  - Acceptance = valid & ready. On acceptance, latch id, we, addr & ~3, wd and in_range (BASE_ADDR ≤ addr ≤ LIMIT_ADDR).
  - Update last_grant on acceptance. Go to ISSUE.
- Requesters must hold valid/addr/we/wd stable until ready. Dropping valid before ready is legal and cancels the request.
- ISSUE, in range: registered outputs drive mem_addr_o = latched addr and mem_wd_o = wd for one cycle; mem_we_o = latched we.
- ISSUE, out of range: mem_addr_o = 0 and mem_we_o = 0; no memory access occurs.
- Outside ISSUE: mem_addr_o = 0, mem_wd_o = 0, mem_we_o = 0.
- CAPTURE: register mem_rd_i. Data is zeroed if the transaction was a write or out of range.
- RESP: pulse reqN_rvalid_o for exactly one cycle to the owner only.
  - reqN_rd_o holds the captured data; reqN_err_o = !in_range.
  - rd_o and err_o read 0 whenever rvalid is low.
  - A write also gets an rvalid pulse as its completion acknowledge.
- Address bits [1:0] are ignored, so misaligned addresses access the containing word.
- Reset: state goes to IDLE and last_grant = 1. All outputs go to 0 on the next edge, and ready is low during reset.
  - An in-flight transaction is dropped with no rvalid.
  - If rst_i rises while in ISSUE, that cycle's mem_we_o is already registered, so the write commits. The requester receives no acknowledge.

## Timing
- Cycle T: acceptance (ready & valid).
- T+1: ISSUE; memory samples mem_addr_o/mem_we_o at the end of T+1.
- T+2: CAPTURE; mem_rd_i is valid and gets registered.
- T+3: RESP; rvalid is high.
- T+4: earliest next acceptance (IDLE), so throughput is one access per 4 cycles.
- A requester's valid held through its own RESP is re-arbitrated in T+4 against the other requester under round-robin.
- A requester that asserts valid during a busy period waits until IDLE. With both requesters continuously valid, grants strictly alternate 0,1,0,1.

## Test plan
- **Reset:** rst_i high for 2 cycles → all outputs 0, req0_ready_o low. Release with req0_valid_i=1 → req0_ready_o=1 in the first cycle after release.
- **Write then read:**
  - req0 writes 0xDEADBEEF to 0x66000010 → mem_we_o=1 and mem_addr_o=0x66000010 at T+1; req0_rvalid_o at T+3 with rd=0, err=0.
  - req0 reads 0x66000012 → mem_addr_o=0x66000010, req0_rd_o=0xDEADBEEF at T+3.
- **Tie:** both valid from reset, reading 0x66000000/0x66000004 → grants req0, req1, req0 at cycles 0, 4, 8. rvalid is seen only on the owner's port.
- **Out of window:** req1 reads 0x66000100, then writes 0x12345678 to 0x65FFFFFC → mem_we_o stays 0, req1_err_o=1, req1_rd_o=0 at T+3. A later read of 0x660000FC is unchanged.
- **Reset mid-transaction:** rst_i asserted in CAPTURE → no rvalid, outputs 0 the next cycle. Re-issued read returns correct data.
- **Cancel:** req1_valid_i pulsed for one cycle while the FSM is busy → no grant to req1 and no memory access.
